// File: rtl/method_call_sequencer.sv
// Upstream driver for a Synthesijer method port: issues NUM_CALLS req/busy handshakes,
// checks each return against EXPECTED and reports done/pass/timeout and per-call latency.
module method_call_sequencer #(
    parameter int                   RET_WIDTH   = 1,
    parameter logic [RET_WIDTH-1:0] EXPECTED    = RET_WIDTH'(1),
    parameter int                   START_DELAY = 100,
    parameter int                   TIMEOUT     = 1000000,
    parameter int                   NUM_CALLS   = 1,
    parameter int                   CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 method_req,
    input  logic                 method_busy,
    input  logic [RET_WIDTH-1:0] method_return,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [15:0]          call_count,
    output logic [15:0]          fail_count,
    output logic [RET_WIDTH-1:0] last_return,
    output logic [CNT_WIDTH-1:0] last_latency
);

    typedef enum logic [2:0] {
        IDLE, DELAY, WAIT_IDLE, ASSERT, WAIT_DONE, CHECK, FINISH
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DELAY_LAST   = CNT_WIDTH'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT  = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [16:0]          NUM_CALLS_W  = 17'(NUM_CALLS);

    state_t                 state, state_n;
    logic                   req_n;
    logic                   done_n, pass_n, timeout_n;
    logic [CNT_WIDTH-1:0]   dly_cnt, dly_n;
    logic [CNT_WIDTH-1:0]   lat_cnt, lat_n, lat_inc;
    logic [CNT_WIDTH-1:0]   last_latency_n;
    logic [15:0]            call_n, fail_n;
    logic [RET_WIDTH-1:0]   last_return_n;

    // The latency counter stops at TIMEOUT so it can never wrap during a hung call.
    assign lat_inc = (lat_cnt >= TIMEOUT_CNT) ? lat_cnt : lat_cnt + CNT_WIDTH'(1);

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_n        = state;
        req_n          = 1'b0;
        done_n         = done;
        pass_n         = pass;
        timeout_n      = timeout;
        dly_n          = dly_cnt;
        lat_n          = lat_cnt;
        call_n         = call_count;
        fail_n         = fail_count;
        last_return_n  = last_return;
        last_latency_n = last_latency;

        if (!enable) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    call_n    = '0;
                    fail_n    = '0;
                    timeout_n = 1'b0;
                    done_n    = 1'b0;
                    pass_n    = 1'b0;
                    dly_n     = '0;
                    state_n   = (START_DELAY == 0) ? WAIT_IDLE : DELAY;
                end
                DELAY: begin
                    dly_n = dly_cnt + CNT_WIDTH'(1);
                    if (dly_cnt == DELAY_LAST) state_n = WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (!method_busy) begin
                        state_n = ASSERT;
                        req_n   = 1'b1;
                        lat_n   = '0;
                    end
                end
                ASSERT: begin
                    lat_n = lat_inc;
                    if (lat_cnt >= TIMEOUT_LAST) begin
                        timeout_n = 1'b1;
                        done_n    = 1'b1;
                        pass_n    = 1'b0;
                        state_n   = FINISH;
                    end else if (method_busy) begin
                        state_n = WAIT_DONE;
                    end else begin
                        req_n = 1'b1;
                    end
                end
                WAIT_DONE: begin
                    lat_n = lat_inc;
                    if (lat_cnt >= TIMEOUT_LAST) begin
                        timeout_n = 1'b1;
                        done_n    = 1'b1;
                        pass_n    = 1'b0;
                        state_n   = FINISH;
                    end else if (!method_busy) begin
                        last_return_n  = method_return;
                        last_latency_n = lat_cnt;
                        state_n        = CHECK;
                    end
                end
                CHECK: begin
                    if (call_count != 16'hFFFF) call_n = call_count + 16'd1;
                    if (last_return != EXPECTED && fail_count != 16'hFFFF)
                        fail_n = fail_count + 16'd1;
                    if ({1'b0, call_count} + 17'd1 >= NUM_CALLS_W) begin
                        done_n  = 1'b1;
                        pass_n  = (fail_n == 16'd0) && !timeout;
                        state_n = FINISH;
                    end else begin
                        state_n = WAIT_IDLE;
                    end
                end
                FINISH: ;
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments; all of it is small flops, so every bit is reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            method_req   <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            dly_cnt      <= '0;
            lat_cnt      <= '0;
            call_count   <= '0;
            fail_count   <= '0;
            last_return  <= '0;
            last_latency <= '0;
        end else begin
            state        <= state_n;
            method_req   <= req_n;
            done         <= done_n;
            pass         <= pass_n;
            timeout      <= timeout_n;
            dly_cnt      <= dly_n;
            lat_cnt      <= lat_n;
            call_count   <= call_n;
            fail_count   <= fail_n;
            last_return  <= last_return_n;
            last_latency <= last_latency_n;
        end
    end

endmodule

// File: doc/method_call_sequencer.md
Name: method_call_sequencer

Overview:
- Synthesizable upstream driver for a Synthesijer-generated method port (the `<m>_req`, `<m>_busy`, `<m>_return` triple).
- Issues NUM_CALLS calls and checks each return against EXPECTED, replacing the free-running req/counter logic of simulation benches with a proper handshake.
- Reports done, pass, per-call latency and a timeout, so the same self-check runs on FPGA or under simulation.
- Sits directly in front of the callee's `<m>_req` input and consumes its `<m>_busy`/`<m>_return` outputs.

Parameters:
- RET_WIDTH, 1, width of method_return.
- EXPECTED, 1, required return value (RET_WIDTH bits).
- START_DELAY, 100, cycles waited after enable before the first call; 0 means no wait.
- TIMEOUT, 1000000, maximum cycles per call from req assertion to busy low.
- NUM_CALLS, 1, number of calls issued; must be ≥1.
- CNT_WIDTH, 32, width of the delay, latency and timeout counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level start; low returns the block to IDLE.
- method_req  out  1  call request to the callee.
- method_busy  in  1  callee busy.
- method_return  in  RET_WIDTH  callee return; valid while busy is low after a call.
- done  out  1  sequence finished (sticky).
- pass  out  1  valid when done: all returns matched and no timeout.
- timeout  out  1  a call exceeded TIMEOUT.
- call_count  out  16  calls completed.
- fail_count  out  16  calls with mismatching return.
- last_return  out  RET_WIDTH  last captured return.
- last_latency  out  CNT_WIDTH  cycles of the last completed call.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, all counters 0.
- States: IDLE, DELAY, WAIT_IDLE, ASSERT, WAIT_DONE, CHECK, FINISH.
- IDLE:
  - Holds outputs.
  - If enable=1: clear call_count, fail_count, timeout, done and pass, then go to DELAY (or WAIT_IDLE if START_DELAY=0).
- DELAY:
  - Counter increments each cycle.
  - On the cycle counter==START_DELAY-1, go to WAIT_IDLE. The first req therefore rises exactly START_DELAY+1 cycles after enable is sampled.
- WAIT_IDLE:
  - Waits for method_busy=0, so a call is never issued into a still-busy callee.
  - Then go to ASSERT, clearing the latency counter to 0.
- ASSERT:
  - method_req=1 (registered, high for every cycle in this state).
  - Latency counter increments each cycle.
  - On method_busy=1, go to WAIT_DONE; req drops in the next cycle.
- WAIT_DONE:
  - method_req=0; latency counter increments each cycle.
  - On method_busy=0: capture method_return into last_return, capture the counter into last_latency, go to CHECK.
- Timeout:
  - If the latency counter reaches TIMEOUT in ASSERT or WAIT_DONE, set timeout=1 and go to FINISH.
  - method_req is forced low in that same next cycle.
  - Timeout takes priority over a simultaneous busy transition.
- CHECK (one cycle):
  - call_count += 1.
  - fail_count += 1 if last_return != EXPECTED.
  - If the new call_count == NUM_CALLS, go to FINISH; otherwise go to WAIT_IDLE.
- FINISH:
  - done=1; pass = (fail_count==0 && timeout==0).
  - Both remain stable while enable=1.
  - enable=0 returns to IDLE; done and pass stay visible until the next enable.
- enable=0 in any other state:
  - Go to IDLE next cycle with method_req=0.
  - Counters and flags are kept, done stays 0.
  - A call in flight is abandoned; the next start re-synchronizes via WAIT_IDLE.
- Counters saturate at all-ones:
  - call_count and fail_count at 16'hFFFF.
  - The latency counter never exceeds TIMEOUT.
- Reset mid-call: immediate return to IDLE, method_req=0 asynchronously.

Test Plan:
- Callee model: busy rises 1 cycle after req and stays high 4 cycles, return=1. START_DELAY=100, enable at cycle 10 -> req rises at cycle 111; done=1, pass=1, call_count=1, last_latency=5.
- Same model with return=0, NUM_CALLS=3 -> fail_count=3, pass=0, done=1, timeout=0.
- Callee never raises busy, TIMEOUT=50 -> req high for exactly 50 cycles; timeout=1, done=1, pass=0, call_count=0.
- Busy held high for 20 cycles after enable, START_DELAY=0 -> req stays 0 until busy falls, then the call proceeds normally.
- reset driven low while in WAIT_DONE -> method_req and all outputs 0 with no clock edge; re-enable completes with pass=1.
- enable dropped mid-sequence with NUM_CALLS=5 after 2 calls -> IDLE, call_count=2, done=0. Re-enable clears the counters and completes all 5 calls.
